pong_match_ctrl: RTL and testbench

PONG_MATCH_CTRL -- requirements
Module: pong_match_ctrl

---
 rtl/pong_match_ctrl_if.sv | 27 ++
 rtl/pong_match_ctrl.sv | 151 +++++++++++++++
 tb/tb_pong_match_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/pong_match_ctrl_if.sv
// Match-controller bus: frame/score events in, ball control and scoreboard out.
interface pong_match_ctrl_if;
  logic       start;
  logic       tick_60Hz;
  logic       point_p1;
  logic       point_p2;
  logic       ball_run;
  logic       ball_load;
  logic       serve_dir;
  logic [3:0] score1;
  logic [3:0] score2;
  logic       game_over;
  logic       winner;
  logic [2:0] state;

  // Controller side
  modport slave (
    input  start, tick_60Hz, point_p1, point_p2,
    output ball_run, ball_load, serve_dir, score1, score2, game_over, winner, state
  );

  // Driver/observer side
  modport master (
    output start, tick_60Hz, point_p1, point_p2,
    input  ball_run, ball_load, serve_dir, score1, score2, game_over, winner, state
  );
endinterface

// File: rtl/pong_match_ctrl.sv
// Pong match controller: serve timing, scoring, win detection and restart.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 120
) (
  input  logic                clk,
  input  logic                reset,
  pong_match_ctrl_if.slave    bus
);

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned SCORE_W = 4;
  localparam int unsigned STATE_W = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SERVE = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_POINT = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score1_q, score1_d;
  logic [SCORE_W-1:0] score2_q, score2_d;
  logic               serve_dir_q, serve_dir_d;
  logic               winner_q, winner_d;
  logic               start_d_q;
  logic               ball_run_q, ball_load_q, game_over_q;
  logic               ball_run_d, ball_load_d, game_over_d;

  logic               start_edge;
  logic [SCORE_W-1:0] score1_inc, score2_inc;

  assign start_edge = bus.start & ~start_d_q;
  assign score1_inc = score1_q + SCORE_W'(1);
  assign score2_inc = score2_q + SCORE_W'(1);

  // Next-state, counter, score and registered-output decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;

    case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          state_d     = S_SERVE;
          serve_dir_d = 1'b0;
        end
      end
      S_SERVE: begin
        if (bus.tick_60Hz) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == SERVE_LAST) state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // point_p1 has priority when both boundaries fire together
        if (bus.point_p1) begin
          score1_d    = score1_inc;
          serve_dir_d = 1'b0;
          if (score1_inc == WIN_VAL) begin
            state_d  = S_OVER;
            winner_d = 1'b0;
          end else begin
            state_d = S_POINT;
            cnt_d   = '0;
          end
        end else if (bus.point_p2) begin
          score2_d    = score2_inc;
          serve_dir_d = 1'b1;
          if (score2_inc == WIN_VAL) begin
            state_d  = S_OVER;
            winner_d = 1'b1;
          end else begin
            state_d = S_POINT;
            cnt_d   = '0;
          end
        end
      end
      S_POINT: begin
        if (bus.tick_60Hz) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == POINT_LAST) state_d = S_SERVE;
        end
      end
      S_OVER: begin
        if (start_edge) begin
          score1_d    = '0;
          score2_d    = '0;
          winner_d    = 1'b0;
          serve_dir_d = 1'b0;
          state_d     = S_SERVE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Every SERVE entry reloads the ball and restarts frame counting
    ball_load_d = (state_d == S_SERVE) && (state_q != S_SERVE);
    if (ball_load_d) cnt_d = '0;

    ball_run_d  = (state_d == S_PLAY);
    game_over_d = (state_d == S_OVER);
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      score1_q    <= '0;
      score2_q    <= '0;
      serve_dir_q <= 1'b0;
      winner_q    <= 1'b0;
      start_d_q   <= 1'b0;
      ball_run_q  <= 1'b0;
      ball_load_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      start_d_q   <= bus.start;
      ball_run_q  <= ball_run_d;
      ball_load_q <= ball_load_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.ball_run  = ball_run_q;
  assign bus.ball_load = ball_load_q;
  assign bus.serve_dir = serve_dir_q;
  assign bus.score1    = score1_q;
  assign bus.score2    = score2_q;
  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl with default parameters.
module tb_pong_match_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  pong_match_ctrl_if bus();

  pong_match_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // All stimulus changes and checks happen at the falling edge
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.tick_60Hz = 1'b1;
      @(negedge clk);
      bus.tick_60Hz = 1'b0;
    end
  endtask

  task automatic pulse_p1();
    bus.point_p1 = 1'b1;
    @(negedge clk);
    bus.point_p1 = 1'b0;
  endtask

  task automatic pulse_p2();
    bus.point_p2 = 1'b1;
    @(negedge clk);
    bus.point_p2 = 1'b0;
  endtask

  task automatic start_edge();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // From POINT: full point delay, serve delay, back in PLAY
  task automatic point_to_play();
    ticks(120);
    ticks(60);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.start     = 1'b0;
    bus.tick_60Hz = 1'b0;
    bus.point_p1  = 1'b0;
    bus.point_p2  = 1'b0;
    idle(2);

    // Reset values
    chk("rst_state",     16'(bus.state), 16'd0);
    chk("rst_score1",    16'(bus.score1), 16'd0);
    chk("rst_score2",    16'(bus.score2), 16'd0);
    chk("rst_ball_run",  16'(bus.ball_run), 16'd0);
    chk("rst_ball_load", 16'(bus.ball_load), 16'd0);
    chk("rst_serve_dir", 16'(bus.serve_dir), 16'd0);
    chk("rst_game_over", 16'(bus.game_over), 16'd0);
    chk("rst_winner",    16'(bus.winner), 16'd0);
    reset = 1'b0;
    idle(2);
    chk("idle_state", 16'(bus.state), 16'd0);
    ticks(3);
    chk("idle_tick_state", 16'(bus.state), 16'd0);

    // Start edge -> SERVE with a one-cycle ball_load; start held high afterwards
    bus.start = 1'b1;
    @(negedge clk);
    chk("serve_state", 16'(bus.state), 16'd1);
    chk("serve_load",  16'(bus.ball_load), 16'd1);
    chk("serve_dir0",  16'(bus.serve_dir), 16'd0);
    @(negedge clk);
    chk("serve_load_off", 16'(bus.ball_load), 16'd0);
    chk("serve_hold",     16'(bus.state), 16'd1);
    ticks(30);
    idle(3);
    pulse_p1();
    chk("serve_p1_ignored", 16'(bus.score1), 16'd0);
    ticks(29);
    chk("serve_59_state", 16'(bus.state), 16'd1);
    chk("serve_59_run",   16'(bus.ball_run), 16'd0);
    ticks(1);
    chk("play_state", 16'(bus.state), 16'd2);
    chk("play_run",   16'(bus.ball_run), 16'd1);
    idle(2);
    chk("play_start_held", 16'(bus.state), 16'd2);
    bus.start = 1'b0;
    @(negedge clk);
    start_edge();
    chk("play_start_edge_ignored", 16'(bus.state), 16'd2);
    ticks(5);
    chk("play_tick_state", 16'(bus.state), 16'd2);

    // Player 2 scores; full POINT -> SERVE -> PLAY cycle
    pulse_p2();
    chk("p2_score2", 16'(bus.score2), 16'd1);
    chk("p2_score1", 16'(bus.score1), 16'd0);
    chk("p2_dir",    16'(bus.serve_dir), 16'd1);
    chk("p2_run",    16'(bus.ball_run), 16'd0);
    chk("p2_state",  16'(bus.state), 16'd3);
    ticks(119);
    chk("point_119_state", 16'(bus.state), 16'd3);
    chk("point_119_load",  16'(bus.ball_load), 16'd0);
    ticks(1);
    chk("point_exit_state", 16'(bus.state), 16'd1);
    chk("point_exit_load",  16'(bus.ball_load), 16'd1);
    ticks(59);
    chk("reserve_59_state", 16'(bus.state), 16'd1);
    ticks(1);
    chk("replay_state", 16'(bus.state), 16'd2);
    chk("replay_run",   16'(bus.ball_run), 16'd1);

    // Simultaneous points: player 1 wins priority
    bus.point_p1 = 1'b1;
    bus.point_p2 = 1'b1;
    @(negedge clk);
    bus.point_p1 = 1'b0;
    bus.point_p2 = 1'b0;
    chk("both_score1", 16'(bus.score1), 16'd1);
    chk("both_score2", 16'(bus.score2), 16'd1);
    chk("both_dir",    16'(bus.serve_dir), 16'd0);
    chk("both_state",  16'(bus.state), 16'd3);
    point_to_play();
    chk("both_replay", 16'(bus.state), 16'd2);

    // Player 1 to 8, then the winning point
    for (int i = 0; i < 7; i++) begin
      pulse_p1();
      point_to_play();
    end
    chk("p1_eight", 16'(bus.score1), 16'd8);
    chk("p1_eight_state", 16'(bus.state), 16'd2);
    pulse_p1();
    chk("win1_score1", 16'(bus.score1), 16'd9);
    chk("win1_state",  16'(bus.state), 16'd4);
    chk("win1_over",   16'(bus.game_over), 16'd1);
    chk("win1_winner", 16'(bus.winner), 16'd0);
    chk("win1_run",    16'(bus.ball_run), 16'd0);
    pulse_p2();
    pulse_p1();
    ticks(4);
    chk("over_score1_held", 16'(bus.score1), 16'd9);
    chk("over_score2_held", 16'(bus.score2), 16'd1);
    chk("over_state_held",  16'(bus.state), 16'd4);

    // Restart from OVER
    start_edge();
    chk("restart_state",  16'(bus.state), 16'd1);
    chk("restart_score1", 16'(bus.score1), 16'd0);
    chk("restart_score2", 16'(bus.score2), 16'd0);
    chk("restart_load",   16'(bus.ball_load), 16'd1);
    chk("restart_over",   16'(bus.game_over), 16'd0);
    chk("restart_dir",    16'(bus.serve_dir), 16'd0);

    // Player 2 wins the second match
    ticks(60);
    chk("m2_play", 16'(bus.state), 16'd2);
    for (int i = 0; i < 8; i++) begin
      pulse_p2();
      point_to_play();
    end
    chk("m2_eight", 16'(bus.score2), 16'd8);
    pulse_p2();
    chk("win2_score2", 16'(bus.score2), 16'd9);
    chk("win2_state",  16'(bus.state), 16'd4);
    chk("win2_winner", 16'(bus.winner), 16'd1);
    chk("win2_dir",    16'(bus.serve_dir), 16'd1);
    start_edge();
    chk("restart2_winner", 16'(bus.winner), 16'd0);
    chk("restart2_dir",    16'(bus.serve_dir), 16'd0);

    // Reset asserted mid-POINT with counter at 50
    ticks(60);
    pulse_p1();
    chk("mid_point_state", 16'(bus.state), 16'd3);
    ticks(50);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state",  16'(bus.state), 16'd0);
    chk("async_rst_score1", 16'(bus.score1), 16'd0);
    chk("async_rst_dir",    16'(bus.serve_dir), 16'd0);
    chk("async_rst_load",   16'(bus.ball_load), 16'd0);
    chk("async_rst_run",    16'(bus.ball_run), 16'd0);
    chk("async_rst_over",   16'(bus.game_over), 16'd0);
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_load", 16'(bus.ball_load), 16'd0);
    ticks(80);
    chk("post_rst_state", 16'(bus.state), 16'd0);
    chk("post_rst_load2", 16'(bus.ball_load), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
